tanh_vector_sequencer: RTL and testbench
========================================

// Module: tanh_vector_sequencer
// PURPOSE
//   Applies tanh element-wise to a vector of IEEE-754 single-precision floats.
//   Time-multiplexes one shared HyperbolicTangent instance: one element per clock.
//   Sits after a layer's matrix-vector product as its activation stage.
//   Start/busy/done handshake to the layer controller.
// PARAMETERS
//   VLEN      8    number of 32-bit float elements per vector (>=1)
//   FP_WIDTH  32   float width; fixed at 32, asserted at elaboration
// PORTS
//   clk      in   1             rising-edge clock
//   rst      in   1             reset; asynchronous, active-high
//   start    in   1             request; sampled only in IDLE
//   vec_in   in   VLEN*32       element i at [32*i+31:32*i]
//   vec_out  out  VLEN*32       tanh results, same packing
//   busy     out  1             high in RUN and DONE
//   done     out  1             one-cycle pulse; vec_out complete and stable
// BEHAVIOUR
//   Reset (async, any state): state=IDLE; idx=0; in_buf=0; vec_out=0; busy=0; done=0.
//   States: IDLE, RUN, DONE.
//   IDLE: start=1 at edge -> in_buf<=vec_in, idx<=0, go RUN. start=0 -> stay.
//   RUN: tanh input = in_buf[idx]; at each edge out_buf[idx]<=tanh result.
//     idx<VLEN-1 -> idx<=idx+1; idx==VLEN-1 -> go DONE, idx<=0.
//   DONE: done=1 for exactly one cycle, then IDLE unconditionally.
//   Latency: start sampled at edge k -> done high in cycle k+VLEN+1.
//   Cycles after start: RUN lasts VLEN cycles, DONE 1.
//   Throughput: one vector per VLEN+2 cycles.
//   start in RUN/DONE is ignored (no queueing).
//   start held high: a new run begins on the first IDLE edge.
//   vec_in is sampled only at the accepting edge; later changes do not affect the run.
//   vec_out is written element-wise during RUN. Only guaranteed coherent while
//     done=1 and afterwards, until the next accepted start.
//   Between runs vec_out holds its last value.
//   Reset mid-RUN: partial results discarded; vec_out=0; no done pulse.
//   VLEN=1: RUN lasts one cycle; idx is 1 bit wide and never increments.
//   Width of idx: max(1,$clog2(VLEN)).
//   Element values are passed bit-exact to and from the tanh core.
//   No rounding or NaN/Inf handling here: special values propagate as the core defines.
// STRUCTURE
//   Shared package/header: FP_WIDTH=32 and state encodings IDLE/RUN/DONE.
//   The shared header is reused by the other layer sequencers.
//   Sub-module: one HyperbolicTangent instance (num=in_buf[idx], result -> out_buf).
//     It is the only combinational datapath.
//   This block holds registers, the index counter and the FSM only.
//   The element select is a VLEN:1 32-bit mux indexed by idx.
// TESTING
//   1 Reset: assert rst mid-run with VLEN=4.
//     -> busy=0, done=0, vec_out=0 immediately; no done pulse follows.
//   2 Basic run, VLEN=4, vec_in={0x41C80000,0x40800000,0x40000000,0xC0000000}
//     (25, 4, 2, -2):
//     -> done at start+5 cycles.
//     -> each element bit-equal to a standalone HyperbolicTangent on the same input.
//     -> values within 1e-3 of: 1.0, 0.99933, 0.96403, -0.96403.
//   3 Zero/sign: vec_in all 0x00000000, then all 0x80000000
//     -> each element is the core's output for that input; done pulses once per run.
//   4 start pulsed during RUN and during DONE -> ignored; exactly one done per accepted start.
//   5 vec_in changed on every cycle after the accepting edge -> results reflect the captured vector only.
//   6 start held high for 3*(VLEN+2) cycles -> back-to-back runs.
//     -> done every VLEN+2 cycles; busy low exactly one cycle between runs.

Source files
------------

// File: rtl/tanh_vector_sequencer_pkg.sv
// Shared definitions for the layer activation sequencers.
// State encoding, float width and tanh core fixed-point constants.
package tanh_vector_sequencer_pkg;

    localparam int FP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    localparam logic [31:0] FP_ONE = 32'h3F80_0000;

    // Tanh core works on |x| in Q.24 inside a 96-bit datapath
    localparam int TANH_FRAC = 24;
    localparam int TANH_W    = 96;

    localparam logic [TANH_W-1:0] ONE_FX = TANH_W'(1) << TANH_FRAC;
    localparam logic [TANH_W-1:0] SAT_FX = TANH_W'(5) << TANH_FRAC;

    localparam logic [TANH_W-1:0] CN0 = TANH_W'(135135);
    localparam logic [TANH_W-1:0] CN1 = TANH_W'(17325);
    localparam logic [TANH_W-1:0] CN2 = TANH_W'(378);
    localparam logic [TANH_W-1:0] CD1 = TANH_W'(62370);
    localparam logic [TANH_W-1:0] CD2 = TANH_W'(3150);
    localparam logic [TANH_W-1:0] CD3 = TANH_W'(28);

    function automatic logic [31:0] fp_unit(input logic sgn);
        return {sgn, FP_ONE[30:0]};
    endfunction

endpackage

// File: rtl/tanh_vector_sequencer_tanh.sv
// Combinational single-precision tanh (HyperbolicTangent core).
// Mid range uses a 7th-order continued-fraction rational in fixed point.
module tanh_vector_sequencer_tanh
    import tanh_vector_sequencer_pkg::*;
(
    input  logic [31:0] num,
    output logic [31:0] result
);

    logic                sgn;
    logic [7:0]          ex;
    logic [22:0]         man;
    logic [3:0]          sh;
    logic [TANH_W-1:0]   x_fx;
    logic [TANH_W-1:0]   x2;
    logic [TANH_W-1:0]   x4;
    logic [TANH_W-1:0]   x6;
    logic [TANH_W-1:0]   p_fx;
    logic [TANH_W-1:0]   q_fx;
    logic [TANH_W-1:0]   t_fx;
    logic [4:0]          lead;
    logic [22:0]         norm;
    logic                is_nan;
    logic                is_big;
    logic                is_small;
    logic                is_mid;

    always_comb begin
        sgn = num[31];
        ex  = num[30:23];
        man = num[22:0];

        is_nan   = (ex == 8'hFF) && (man != 23'd0);
        is_big   = (ex >= 8'd130) && !is_nan;
        is_small = (ex < 8'd115);
        is_mid   = (ex >= 8'd115) && (ex < 8'd130);

        // |x| in [2^-12, 8): align {1,man} so that x_fx = |x| * 2^24
        sh   = 4'(ex - 8'd115);
        x_fx = (TANH_W'({1'b1, man}) << sh) >> 11;

        x2 = (x_fx * x_fx) >> TANH_FRAC;
        x4 = (x2 * x2) >> TANH_FRAC;
        x6 = (x4 * x2) >> TANH_FRAC;

        p_fx = (CN0 << TANH_FRAC) + CN1 * x2 + CN2 * x4 + x6;
        q_fx = (CN0 << TANH_FRAC) + CD1 * x2 + CD2 * x4 + CD3 * x6;
        t_fx = (x_fx * p_fx) / q_fx;

        lead = 5'd0;
        for (int i = 0; i < TANH_FRAC; i++) begin
            if (t_fx[i]) lead = 5'(i);
        end
        norm = t_fx[22:0] << (5'd23 - lead);

        result = num;
        unique case (1'b1)
            is_nan:   result = num;
            is_big:   result = fp_unit(sgn);
            is_small: result = num;
            is_mid: begin
                if (t_fx >= ONE_FX || x_fx >= SAT_FX) begin
                    result = fp_unit(sgn);
                end else begin
                    result = {sgn, 8'(lead) + 8'd103, norm};
                end
            end
            default:  result = num;
        endcase
    end

endmodule

// File: rtl/tanh_vector_sequencer.sv
// Element-wise tanh over a float vector, one element per clock.
// Start/busy/done handshake toward the layer controller.
module tanh_vector_sequencer
    import tanh_vector_sequencer_pkg::*;
#(
    parameter int VLEN     = 8,
    parameter int FP_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [VLEN*FP_WIDTH-1:0] vec_in,
    output logic [VLEN*FP_WIDTH-1:0] vec_out,
    output logic                     busy,
    output logic                     done
);

    localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(VLEN - 1);

    if (FP_WIDTH != tanh_vector_sequencer_pkg::FP_WIDTH) begin : g_bad_width
        $error("tanh_vector_sequencer: FP_WIDTH must be 32");
    end
    if (VLEN < 1) begin : g_bad_vlen
        $error("tanh_vector_sequencer: VLEN must be >= 1");
    end

    seq_state_e state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [VLEN-1:0][FP_WIDTH-1:0] in_buf_q, in_buf_d;
    logic [VLEN-1:0][FP_WIDTH-1:0] out_buf_q, out_buf_d;
    logic [FP_WIDTH-1:0] elem;
    logic [FP_WIDTH-1:0] tanh_res;

    assign elem = in_buf_q[idx_q];

    tanh_vector_sequencer_tanh u_hyperbolic_tangent (
        .num    (elem),
        .result (tanh_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            in_buf_q  <= '0;
            out_buf_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            in_buf_q  <= in_buf_d;
            out_buf_q <= out_buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        in_buf_d  = in_buf_q;
        out_buf_d = out_buf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    in_buf_d = vec_in;
                    idx_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                out_buf_d[idx_q] = tanh_res;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign vec_out = out_buf_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_tanh_vector_sequencer.sv
// Scoreboard bench for tanh_vector_sequencer (VLEN=4).
// Expected results come from real-valued tanh of the captured inputs.
module tb_tanh_vector_sequencer;

    localparam int VLEN = 4;
    localparam int VW   = VLEN * 32;
    localparam real TOL = 1.0e-3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [VW-1:0] vec_in;
    logic [VW-1:0] vec_out;
    logic          busy;
    logic          done;
    logic [31:0]   ref_num;
    logic [31:0]   ref_res;

    int checks;
    int failures;
    int done_seen;
    int done_pred;
    int mdl_c;
    logic [VW-1:0] sb_q[$];

    tanh_vector_sequencer #(.VLEN(VLEN), .FP_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .vec_in  (vec_in),
        .vec_out (vec_out),
        .busy    (busy),
        .done    (done)
    );

    tanh_vector_sequencer_tanh ref_core (
        .num    (ref_num),
        .result (ref_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        m = real'(b[22:0]) / 8388608.0;
        if (e == 0) e = 1;
        else m = m + 1.0;
        for (int i = 0; i < e - 127; i++) m = m * 2.0;
        for (int i = 0; i < 127 - e; i++) m = m / 2.0;
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] rand_elem();
        logic [31:0] r;
        r = $urandom;
        r[30:23] = 8'($urandom_range(105, 134));
        if ($urandom_range(0, 15) == 0) r[30:0] = '0;
        return r;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VLEN; i++) v[i*32 +: 32] = rand_elem();
        return v;
    endfunction

    task automatic chk(input string name, input logic [VW-1:0] got,
                       input logic [VW-1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic chk_real(input string name, input real got, input real want);
        checks++;
        if (got - want > TOL || want - got > TOL) begin
            failures++;
            $display("FAIL %s got=%f want=%f", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [VW-1:0] v);
        start  = 1'b1;
        vec_in = v;
        tick();
        start  = 1'b0;
    endtask

    // Monitor: cycle-level model of accept/run/done plus result scoreboard
    initial begin
        logic [VW-1:0] exp_v;
        logic [31:0]   ein;
        logic [31:0]   eout;
        mdl_c = -1;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_busy", VW'(busy), VW'(0));
                chk("rst_done", VW'(done), VW'(0));
                chk("rst_vec_out", vec_out, '0);
                mdl_c = -1;
                sb_q.delete();
            end else begin
                chk("busy", VW'(busy), VW'(mdl_c >= 0));
                chk("done", VW'(done), VW'(mdl_c == VLEN));
                if (mdl_c == VLEN) done_pred++;
                if (done) begin
                    done_seen++;
                    checks++;
                    if (sb_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_empty got=done want=no_done");
                    end else begin
                        exp_v = sb_q.pop_front();
                        for (int i = 0; i < VLEN; i++) begin
                            ein  = exp_v[i*32 +: 32];
                            eout = vec_out[i*32 +: 32];
                            if (ein[30:0] == 31'd0)
                                chk("zero_elem", VW'(eout), VW'(ein));
                            else
                                chk_real("tanh_elem", f2r(eout), $tanh(f2r(ein)));
                        end
                    end
                end
                if (mdl_c < 0) begin
                    if (start) begin
                        sb_q.push_back(vec_in);
                        mdl_c = 0;
                    end
                end else if (mdl_c == VLEN) begin
                    mdl_c = -1;
                end else begin
                    mdl_c++;
                end
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        failures++;
        $display("FAIL watchdog got=timeout want=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [VW-1:0] v2;
        logic [VW-1:0] vz;
        logic [31:0]   e;
        real           want2[VLEN];
        int            lat;

        checks = 0;
        failures = 0;
        done_seen = 0;
        done_pred = 0;
        rst = 1'b1;
        start = 1'b0;
        vec_in = '0;
        ref_num = '0;
        tick();
        tick();
        chk("reset_busy", VW'(busy), VW'(0));
        chk("reset_done", VW'(done), VW'(0));
        chk("reset_vec_out", vec_out, '0);
        rst = 1'b0;
        tick();

        // Basic run: (25, 4, 2, -2)
        v2 = {32'h41C8_0000, 32'h4080_0000, 32'h4000_0000, 32'hC000_0000};
        want2[3] = 1.0;
        want2[2] = 0.99933;
        want2[1] = 0.96403;
        want2[0] = -0.96403;
        issue(v2);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        chk("latency", VW'(lat), VW'(VLEN));
        for (int i = 0; i < VLEN; i++)
            chk_real("basic_value", f2r(vec_out[i*32 +: 32]), want2[i]);
        tick();
        for (int i = 0; i < VLEN; i++) begin
            e = v2[i*32 +: 32];
            ref_num = e;
            #1;
            chk("core_bit_equal", VW'(vec_out[i*32 +: 32]), VW'(ref_res));
        end
        repeat (2) tick();

        // Zero and negative zero
        vz = '0;
        issue(vz);
        repeat (VLEN + 2) tick();
        for (int i = 0; i < VLEN; i++) vz[i*32 +: 32] = 32'h8000_0000;
        issue(vz);
        repeat (VLEN + 2) tick();

        // Reset in the middle of a run
        issue(rand_vec());
        repeat (2) tick();
        rst = 1'b1;
        #1;
        chk("midrun_busy", VW'(busy), VW'(0));
        chk("midrun_done", VW'(done), VW'(0));
        chk("midrun_vec_out", vec_out, '0);
        tick();
        rst = 1'b0;
        repeat (VLEN + 3) tick();

        // start pulsed during RUN and DONE
        issue(rand_vec());
        start = 1'b1;
        vec_in = rand_vec();
        tick();
        start = 1'b0;
        repeat (VLEN - 1) tick();
        start = 1'b1;
        vec_in = rand_vec();
        tick();
        start = 1'b0;
        repeat (VLEN + 2) tick();

        // vec_in scrambled after the accepting edge
        issue(rand_vec());
        repeat (VLEN + 1) begin
            vec_in = rand_vec();
            tick();
        end
        tick();

        // start held high: back-to-back runs
        start = 1'b1;
        repeat (3 * (VLEN + 2)) begin
            vec_in = rand_vec();
            tick();
        end
        start = 1'b0;
        repeat (2 * (VLEN + 2)) tick();

        // Random runs with random gaps
        for (int n = 0; n < 30; n++) begin
            issue(rand_vec());
            repeat ($urandom_range(0, VLEN + 3)) tick();
        end
        repeat (2 * (VLEN + 2)) tick();

        chk("sb_drained", VW'(sb_q.size()), VW'(0));
        chk("done_count", VW'(done_seen), VW'(done_pred));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
